// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, registered operand
// issue, a fixed settle wait, then a one-cycle registered response pulse.
module alu_share_arbiter #(
    parameter int N    = 64,
    parameter int WAIT = 2
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic         Req0Valid,
    output logic         Req0Ready,
    input  logic [N-1:0] Req0A,
    input  logic [N-1:0] Req0B,
    input  logic [3:0]   Req0Ctrl,
    input  logic         Req1Valid,
    output logic         Req1Ready,
    input  logic [N-1:0] Req1A,
    input  logic [N-1:0] Req1B,
    input  logic [3:0]   Req1Ctrl,
    output logic [N-1:0] ALUBusA,
    output logic [N-1:0] ALUBusB,
    output logic [3:0]   ALUCtrl,
    input  logic [N-1:0] ALUBusW,
    input  logic         ALUZero,
    output logic         RespValid,
    output logic         RespID,
    output logic [N-1:0] RespW,
    output logic         RespZero,
    output logic         RespErr,
    output logic         Busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [3:0] CountInit = 4'(WAIT - 1);

    state_t       state;
    logic [3:0]   count;
    logic         lastGrant;
    logic         owner;
    logic         errFlag;

    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [N-1:0] selA;
    logic [N-1:0] selB;
    logic [3:0]   selCtrl;
    logic         selLegal;

    // 1xx0 covers the MOVZ family; the ALU decodes the shift amount itself.
    function automatic logic isLegal(input logic [3:0] code);
        return (code == 4'b0000) || (code == 4'b0001) || (code == 4'b0010) ||
               (code == 4'b0110) || (code == 4'b0111) || (code[3] && !code[0]);
    endfunction

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (state == IDLE) begin
            grant0 = Req0Valid && (!Req1Valid || lastGrant);
            grant1 = Req1Valid && (!Req0Valid || !lastGrant);
        end
        accept   = grant0 || grant1;
        selA     = grant1 ? Req1A    : Req0A;
        selB     = grant1 ? Req1B    : Req0B;
        selCtrl  = grant1 ? Req1Ctrl : Req0Ctrl;
        selLegal = isLegal(selCtrl);
    end

    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state     <= IDLE;
            count     <= '0;
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            errFlag   <= 1'b0;
            ALUBusA   <= '0;
            ALUBusB   <= '0;
            ALUCtrl   <= 4'b0000;
            RespValid <= 1'b0;
            RespID    <= 1'b0;
            RespW     <= '0;
            RespZero  <= 1'b0;
            RespErr   <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            RespValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lastGrant <= grant1;
                        owner     <= grant1;
                        count     <= CountInit;
                        errFlag   <= !selLegal;
                        state     <= EXEC;
                        Busy      <= 1'b1;
                        // Illegal ops leave the ALU buses on the last legal op.
                        if (selLegal) begin
                            ALUBusA <= selA;
                            ALUBusB <= selB;
                            ALUCtrl <= selCtrl;
                        end
                    end
                end
                EXEC: begin
                    if (count == 4'd0) begin
                        RespW     <= errFlag ? '0 : ALUBusW;
                        RespZero  <= errFlag ? 1'b0 : ALUZero;
                        RespErr   <= errFlag;
                        RespID    <= owner;
                        RespValid <= 1'b1;
                        state     <= IDLE;
                        Busy      <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a behavioural ALU drives the result
// bus, a reference model predicts grants and responses, a monitor checks them.
module tb_alu_share_arbiter;

    localparam int N    = 64;
    localparam int WAIT = 2;

    logic         CLK;
    logic         Reset_L;
    logic         Req0Valid, Req0Ready, Req1Valid, Req1Ready;
    logic [N-1:0] Req0A, Req0B, Req1A, Req1B;
    logic [3:0]   Req0Ctrl, Req1Ctrl;
    logic [N-1:0] ALUBusA, ALUBusB, ALUBusW, RespW;
    logic [3:0]   ALUCtrl;
    logic         ALUZero, RespValid, RespID, RespZero, RespErr, Busy;

    alu_share_arbiter #(.N(N), .WAIT(WAIT)) dut (
        .CLK(CLK), .Reset_L(Reset_L),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B), .Req0Ctrl(Req0Ctrl),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B), .Req1Ctrl(Req1Ctrl),
        .ALUBusA(ALUBusA), .ALUBusB(ALUBusB), .ALUCtrl(ALUCtrl), .ALUBusW(ALUBusW), .ALUZero(ALUZero),
        .RespValid(RespValid), .RespID(RespID), .RespW(RespW), .RespZero(RespZero),
        .RespErr(RespErr), .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] refAlu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return (c[3] && !c[0]) ? (b << (16 * int'(c[2:1]))) : 64'd0;
        endcase
    endfunction

    function automatic logic refLegal(input logic [3:0] c);
        return (c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd12, 4'd14});
    endfunction

    assign ALUBusW = refAlu(ALUBusA, ALUBusB, ALUCtrl);
    assign ALUZero = (ALUBusW == '0);

    typedef struct {
        logic        id;
        logic [63:0] w;
        logic        zero;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          nTests = 0;
    int          nFail  = 0;
    int          cyc    = 0;
    int          freeCyc = 0;
    logic        mLast = 1'b1;
    logic [63:0] mA = '0, mB = '0;
    logic [3:0]  mCtrl = '0;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    logic        got0 = 1'b0, got1 = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(posedge CLK) cyc = cyc + 1;

    // Monitor and reference model: everything sampled on the falling edge.
    always @(negedge CLK) begin : monitor
        exp_t        e;
        logic        bExp, e0, e1, id, legal;
        logic [63:0] a, b;
        logic [3:0]  c;
        if (!Reset_L) begin
            check("reset_outputs", {Req0Ready, Req1Ready, RespValid, RespID, RespZero, RespErr, Busy,
                                    |ALUBusA, |ALUBusB, |ALUCtrl, |RespW}, 64'd0);
            sbq.delete();
            freeCyc = 0; mLast = 1'b1; mA = '0; mB = '0; mCtrl = '0;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            bExp = (cyc < freeCyc);
            check("busy", Busy, bExp);
            check("alu_a", ALUBusA, mA);
            check("alu_b", ALUBusB, mB);
            check("alu_ctrl", ALUCtrl, mCtrl);
            if (RespValid) begin
                if (sbq.size() == 0) begin
                    nTests++; nFail++;
                    $display("FAIL resp_unexpected: got RespValid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("resp_cycle", cyc, e.due);
                    check("resp_id", RespID, e.id);
                    check("resp_w", RespW, e.w);
                    check("resp_zero", RespZero, e.zero);
                    check("resp_err", RespErr, e.err);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                nTests++; nFail++;
                $display("FAIL resp_missing: got no RespValid expected one at cycle %0d", e.due);
            end
            e0 = !bExp && Req0Valid && (!Req1Valid || mLast);
            e1 = !bExp && Req1Valid && (!Req0Valid || !mLast);
            check("ready0", Req0Ready, e0);
            check("ready1", Req1Ready, e1);
            acc0 = e0;
            acc1 = e1;
            if (e0 || e1) begin
                id    = e1;
                a     = id ? Req1A : Req0A;
                b     = id ? Req1B : Req0B;
                c     = id ? Req1Ctrl : Req0Ctrl;
                legal = refLegal(c);
                e.id   = id;
                e.w    = legal ? refAlu(a, b, c) : 64'd0;
                e.zero = legal && (refAlu(a, b, c) == 64'd0);
                e.err  = !legal;
                e.due  = cyc + 1 + WAIT;
                sbq.push_back(e);
                freeCyc = cyc + 1 + WAIT;
                mLast   = id;
                if (legal) begin
                    mA = a; mB = b; mCtrl = c;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        got0 = acc0;
        got1 = acc1;
        if (got0) Req0Valid = 1'b0;
        if (got1) Req1Valid = 1'b0;
    endtask

    task automatic present(input logic id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        if (!id) begin
            Req0A = a; Req0B = b; Req0Ctrl = c; Req0Valid = 1'b1;
        end else begin
            Req1A = a; Req1B = b; Req1Ctrl = c; Req1Valid = 1'b1;
        end
    endtask

    task automatic waitAccept(input logic id, output int steps);
        bit done = 1'b0;
        steps = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            steps++;
            done = id ? got1 : got0;
        end
        if (!done) begin
            nTests++; nFail++;
            $display("FAIL accept_timeout: got no accept expected requester %0d granted", id);
            Req0Valid = 1'b0; Req1Valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sbq.size() != 0); i++) step();
        step();
    endtask

    task automatic runOp(input logic id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        int s;
        present(id, a, b, c);
        waitAccept(id, s);
        drain();
    endtask

    task automatic randOp(input logic id);
        logic [3:0]  legalCodes [9] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd12, 4'd14};
        logic [63:0] a, b;
        logic [3:0]  c;
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
        c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legalCodes[$urandom_range(0, 8)];
        present(id, a, b, c);
    endtask

    task automatic pulseReset();
        Reset_L   = 1'b0;
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        #1;
        check("reset_immediate", {RespValid, Busy, |ALUBusA, |ALUBusB, |ALUCtrl, |RespW, RespErr}, 64'd0);
        step();
        Reset_L = 1'b1;
    endtask

    initial begin : stimulus
        int grants[$];
        int accCyc[$];
        int s;
        Reset_L = 1'b1;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        Req0A = '0; Req0B = '0; Req0Ctrl = '0;
        Req1A = '0; Req1B = '0; Req1Ctrl = '0;
        #1 Reset_L = 1'b0;
        repeat (3) step();
        Reset_L = 1'b1;

        // Both requesters held: alternate grants starting with 0 after reset.
        present(0, 64'd1, 64'd2, 4'b0010);
        present(1, 64'd3, 64'd4, 4'b0001);
        for (int i = 0; i < 60 && grants.size() < 4; i++) begin
            step();
            if (got0) begin grants.push_back(0); accCyc.push_back(cyc); end
            if (got1) begin grants.push_back(1); accCyc.push_back(cyc); end
            if (got0 && grants.size() < 4) present(0, 64'(i), 64'd7, 4'b0010);
            if (got1 && grants.size() < 4) present(1, 64'(i), 64'd9, 4'b0110);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        check("grant_count", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++) begin
            check("grant_order", grants[k], k % 2);
            if (k > 0) check("accept_gap_ok", (accCyc[k] - accCyc[k-1]) <= WAIT + 1, 1);
        end
        drain();

        runOp(0, 64'd5, 64'd7, 4'b0010);
        check("add_w", RespW, 64'd12);
        check("add_zero", RespZero, 0);
        check("add_id", RespID, 0);
        check("add_err", RespErr, 0);

        runOp(1, 64'd9, 64'd9, 4'b0110);
        check("sub_w", RespW, 64'd0);
        check("sub_zero", RespZero, 1);
        check("sub_id", RespID, 1);

        runOp(1, 64'd123, 64'd1, 4'b1010);
        check("movz_w", RespW, 64'h10000);
        check("movz_zero", RespZero, 0);

        runOp(0, 64'd3, 64'd4, 4'b0011);
        check("illegal_err", RespErr, 1);
        check("illegal_w", RespW, 64'd0);
        check("illegal_zero", RespZero, 0);
        check("illegal_keeps_ctrl", ALUCtrl, 4'b1010);

        // Reset one cycle into EXEC drops the op; Req1 alone wins immediately after.
        present(0, 64'd11, 64'd22, 4'b0010);
        waitAccept(0, s);
        pulseReset();
        check("drop_busy", Busy, 0);
        present(1, 64'd40, 64'd2, 4'b0010);
        waitAccept(1, s);
        check("first_idle_grant", s, 1);
        drain();

        for (int i = 0; i < 400; i++) begin
            if (!Req0Valid && $urandom_range(0, 1) == 1) randOp(0);
            if (!Req1Valid && $urandom_range(0, 1) == 1) randOp(1);
            if (i == 200) pulseReset();
            else step();
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
